// File: rtl/wr_pattern_pkg.sv
// Shared definitions for the wr_pattern command sequencer: ROM tag encoding,
// sequencer state encoding and default ROM geometry.
package wr_pattern_pkg;

    localparam int unsigned ROM_AW_DEF = 8;
    localparam int unsigned ROM_DW_DEF = 34;
    localparam int unsigned BUS_W_DEF  = 32;
    localparam int unsigned TAG_W      = 2;

    localparam logic [TAG_W-1:0] TAG_END  = 2'b00;
    localparam logic [TAG_W-1:0] TAG_CFG  = 2'b01;
    localparam logic [TAG_W-1:0] TAG_ADDR = 2'b10;
    localparam logic [TAG_W-1:0] TAG_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Tag field sits in the two MSBs of a ROM word.
    function automatic logic [TAG_W-1:0] word_tag(input logic [ROM_DW_DEF-1:0] word);
        return word[ROM_DW_DEF-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/wr_pattern_seq_if.sv
// Memory-mapped write port: valid/ready handshake carrying address and data.
interface wr_pattern_seq_if #(
    parameter int unsigned BUS_W = 32
);

    logic             wr_valid;
    logic             wr_ready;
    logic [BUS_W-1:0] wr_addr;
    logic [BUS_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/wr_pattern_seq.sv
// Executes the wr_pattern ROM program: ADDR/DATA words become bus writes, CFG words
// become one-cycle strobes. Optional WR_PATTERN_SEQ_ADDR_INC_EN auto-increments the address.
module wr_pattern_seq
    import wr_pattern_pkg::*;
#(
    parameter int unsigned ROM_AW   = ROM_AW_DEF,
    parameter int unsigned ROM_DW   = ROM_DW_DEF,
    parameter int unsigned BUS_W    = BUS_W_DEF,
    parameter int unsigned START_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_DW-1:0] rom_data,
    wr_pattern_seq_if.master  wr,
    output logic              cfg_we,
    output logic [BUS_W-1:0]  cfg_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
    localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
    localparam logic [2:0] S_WRITE  = 3'(ST_WRITE);
    localparam logic [2:0] S_DONE   = 3'(ST_DONE);

    localparam logic [ROM_AW-1:0] PC_START  = ROM_AW'(START_PC);
    localparam logic [ROM_AW-1:0] PC_LAST   = '1;
    localparam logic [ROM_AW-1:0] PC_STEP   = ROM_AW'(1);
    localparam logic [BUS_W-1:0]  ADDR_STEP = BUS_W'(4);

`ifdef WR_PATTERN_SEQ_ADDR_INC_EN
    localparam bit ADDR_INC = 1'b1;
`else
    localparam bit ADDR_INC = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic [ROM_AW-1:0] pc_q, pc_d;
    logic [BUS_W-1:0]  addr_q, addr_d;
    logic              addr_vld_q, addr_vld_d;

    logic              rom_en_d;
    logic              wr_valid_d;
    logic [BUS_W-1:0]  wr_addr_d;
    logic [BUS_W-1:0]  wr_data_d;
    logic              cfg_we_d;
    logic [BUS_W-1:0]  cfg_data_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;

    logic [TAG_W-1:0]  tag_c;
    logic [BUS_W-1:0]  payload_c;
    logic              at_last_c;

    assign tag_c     = rom_data[ROM_DW-1 -: TAG_W];
    assign payload_c = rom_data[BUS_W-1:0];
    assign at_last_c = (pc_q == PC_LAST);
    assign rom_addr  = pc_q;

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            addr_q      <= '0;
            addr_vld_q  <= 1'b0;
            rom_en      <= 1'b0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            cfg_we      <= 1'b0;
            cfg_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            addr_vld_q  <= addr_vld_d;
            rom_en      <= rom_en_d;
            wr.wr_valid <= wr_valid_d;
            wr.wr_addr  <= wr_addr_d;
            wr.wr_data  <= wr_data_d;
            cfg_we      <= cfg_we_d;
            cfg_data    <= cfg_data_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        addr_vld_d = addr_vld_q;
        rom_en_d   = 1'b0;
        wr_valid_d = wr.wr_valid;
        wr_addr_d  = wr.wr_addr;
        wr_data_d  = wr.wr_data;
        cfg_we_d   = 1'b0;
        cfg_data_d = cfg_data;
        err_d      = err;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    pc_d       = PC_START;
                    addr_vld_d = 1'b0;
                    err_d      = 1'b0;
                    rom_en_d   = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = abort ? S_DONE : S_DECODE;
            end

            S_DECODE: begin
                if (abort) begin
                    state_d = S_DONE;
                end else begin
                    case (tag_c)
                        TAG_CFG, TAG_ADDR: begin
                            if (tag_c == TAG_CFG) begin
                                cfg_we_d   = 1'b1;
                                cfg_data_d = payload_c;
                            end else begin
                                addr_d     = payload_c;
                                addr_vld_d = 1'b1;
                            end
                            // The last ROM address must hold END; running past it is an error.
                            if (at_last_c) begin
                                state_d = S_DONE;
                                err_d   = 1'b1;
                            end else begin
                                state_d  = S_FETCH;
                                pc_d     = pc_q + PC_STEP;
                                rom_en_d = 1'b1;
                            end
                        end
                        TAG_DATA: begin
                            if (addr_vld_q) begin
                                state_d    = S_WRITE;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = addr_q;
                                wr_data_d  = payload_c;
                            end else begin
                                state_d = S_DONE;
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                // Request is held until accepted; abort only takes effect afterwards.
                if (wr.wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (ADDR_INC) begin
                        addr_d = addr_q + ADDR_STEP;
                    end
                    if (abort) begin
                        state_d = S_DONE;
                    end else if (at_last_c) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_FETCH;
                        pc_d     = pc_q + PC_STEP;
                        rom_en_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // Handshake and strobe protocol properties.
    wr_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        (wr.wr_valid && !wr.wr_ready) |=>
        (wr.wr_valid && $stable(wr.wr_addr) && $stable(wr.wr_data)));

    cfg_pulse_a: assert property (@(posedge clk) disable iff (!rst_n)
        cfg_we |=> !cfg_we);

endmodule

// File: tb/tb_wr_pattern_seq.sv
// Directed self-checking bench for wr_pattern_seq with a synchronous ROM model;
// follows WR_PATTERN_SEQ_ADDR_INC_EN for the address-increment expectations.
module tb_wr_pattern_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [33:0] rom_data;
    logic        cfg_we;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [33:0] rom_mem [256];

    wr_pattern_seq_if #(.BUS_W(32)) bus ();

    wr_pattern_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr       (bus),
        .cfg_we   (cfg_we),
        .cfg_data (cfg_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    // Bus / strobe log, sampled mid-cycle.
    logic [31:0] wr_a_log [$];
    logic [31:0] wr_d_log [$];
    logic [31:0] cfg_log  [$];
    int          n_fetch = 0;
    int          n_valid = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_valid) n_valid++;
            if (bus.wr_valid && bus.wr_ready) begin
                wr_a_log.push_back(bus.wr_addr);
                wr_d_log.push_back(bus.wr_data);
            end
            if (cfg_we) cfg_log.push_back(cfg_data);
            if (rom_en) n_fetch++;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 34'h0;
    endtask

    // Pulse start; returns in the first cycle after the accepting edge.
    task automatic do_start(input logic with_abort);
        @(posedge clk); #1;
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit timeout);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        timeout = !done;
        @(negedge clk); #1;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit timeout);
        cycles = 0;
        while (!bus.wr_valid && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        timeout = !bus.wr_valid;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rom_en, bus.wr_valid, cfg_we, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {rom_en, bus.wr_valid, cfg_we, busy, done, err});
        end
        checks++;
        if ({rom_addr, bus.wr_addr, bus.wr_data, cfg_data} !== 104'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h %h %h %h expected all zero",
                     rom_addr, bus.wr_addr, bus.wr_data, cfg_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, rom_en} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {busy, done, rom_en});
        end
    endtask

    task automatic test_addr_data_end();
        int cyc; bit to; int bw;
        clear_rom();
        rom_mem[0] = 34'h290000100;
        rom_mem[1] = 34'h3c0000014;
        rom_mem[2] = 34'h0;
        bus.wr_ready = 1'b1;
        bw = wr_a_log.size();
        do_start(1'b0);
        checks++;
        if ({rom_en, busy, rom_addr} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL first_fetch: got en=%b busy=%b addr=%h expected 1 1 00",
                     rom_en, busy, rom_addr);
        end
        wait_done(50, cyc, to);
        checks++;
        if (to || cyc != 7) begin
            errors++;
            $display("FAIL ade_latency: got %0d (timeout=%0d) expected 7", cyc, to);
        end
        checks++;
        if (wr_a_log.size() - bw != 1) begin
            errors++;
            $display("FAIL ade_write_count: got %0d expected 1", wr_a_log.size() - bw);
        end else begin
            checks++;
            if (wr_a_log[bw] !== 32'h90000100 || wr_d_log[bw] !== 32'hC0000014) begin
                errors++;
                $display("FAIL ade_write: got %h/%h expected 90000100/c0000014",
                         wr_a_log[bw], wr_d_log[bw]);
            end
        end
        checks++;
        if ({done, err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL ade_status: got done=%b err=%b busy=%b expected 1 0 0", done, err, busy);
        end
    endtask

    task automatic test_cfg_burst();
        int cyc; bit to; int bc; int bv;
        clear_rom();
        rom_mem[0] = 34'h180001fff;
        rom_mem[1] = 34'h182000008;
        bc = cfg_log.size();
        bv = n_valid;
        do_start(1'b0);
        wait_done(50, cyc, to);
        checks++;
        if (to || cyc != 6) begin
            errors++;
            $display("FAIL cfg_latency: got %0d (timeout=%0d) expected 6", cyc, to);
        end
        checks++;
        if (cfg_log.size() - bc != 2) begin
            errors++;
            $display("FAIL cfg_count: got %0d expected 2", cfg_log.size() - bc);
        end else begin
            checks++;
            if (cfg_log[bc] !== 32'h80001FFF || cfg_log[bc+1] !== 32'h82000008) begin
                errors++;
                $display("FAIL cfg_data: got %h %h expected 80001fff 82000008",
                         cfg_log[bc], cfg_log[bc+1]);
            end
        end
        checks++;
        if (n_valid != bv) begin
            errors++;
            $display("FAIL cfg_no_write: got %0d valid cycles expected 0", n_valid - bv);
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit to; int bv; int bw;
        clear_rom();
        rom_mem[0] = 34'h290000100;
        rom_mem[1] = 34'h3c0000014;
        bus.wr_ready = 1'b0;
        bv = n_valid;
        bw = wr_a_log.size();
        do_start(1'b0);
        wait_valid(20, cyc, to);
        checks++;
        if (to || cyc != 4) begin
            errors++;
            $display("FAIL bp_valid_latency: got %0d (timeout=%0d) expected 4", cyc, to);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.wr_valid, bus.wr_addr, bus.wr_data, rom_addr} !==
                {1'b1, 32'h90000100, 32'hC0000014, 8'h01}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b %h/%h pc=%h expected 1 90000100/c0000014 pc=01",
                         i, bus.wr_valid, bus.wr_addr, bus.wr_data, rom_addr);
            end
            @(posedge clk); #1;
        end
        bus.wr_ready = 1'b1;
        checks++;
        if (bus.wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_sixth: got wr_valid=%b expected 1", bus.wr_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.wr_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL bp_advance: got v=%b en=%b pc=%h expected 0 1 02",
                     bus.wr_valid, rom_en, rom_addr);
        end
        wait_done(50, cyc, to);
        checks++;
        if (to || n_valid - bv != 6 || wr_a_log.size() - bw != 1) begin
            errors++;
            $display("FAIL bp_totals: got valid=%0d writes=%0d timeout=%0d expected 6 1 0",
                     n_valid - bv, wr_a_log.size() - bw, to);
        end
    endtask

    task automatic test_data_no_addr();
        int cyc; bit to; int bv;
        clear_rom();
        rom_mem[0] = 34'h312341234;
        bv = n_valid;
        do_start(1'b0);
        wait_done(50, cyc, to);
        checks++;
        if (to || cyc != 2) begin
            errors++;
            $display("FAIL dna_latency: got %0d (timeout=%0d) expected 2", cyc, to);
        end
        checks++;
        if ({done, err} !== 2'b11 || n_valid != bv) begin
            errors++;
            $display("FAIL dna_status: got done=%b err=%b valid=%0d expected 1 1 0",
                     done, err, n_valid - bv);
        end
    endtask

    task automatic test_addr_inc();
        int cyc; bit to; int bw; logic [31:0] exp2;
`ifdef WR_PATTERN_SEQ_ADDR_INC_EN
        exp2 = 32'h80001234;
`else
        exp2 = 32'h80001230;
`endif
        clear_rom();
        rom_mem[0] = 34'h280001230;
        rom_mem[1] = 34'h311111111;
        rom_mem[2] = 34'h322222222;
        bus.wr_ready = 1'b1;
        bw = wr_a_log.size();
        do_start(1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", err);
        end
        wait_done(50, cyc, to);
        checks++;
        if (to || cyc != 10) begin
            errors++;
            $display("FAIL inc_latency: got %0d (timeout=%0d) expected 10", cyc, to);
        end
        checks++;
        if (wr_a_log.size() - bw != 2) begin
            errors++;
            $display("FAIL inc_count: got %0d expected 2", wr_a_log.size() - bw);
        end else begin
            checks++;
            if (wr_a_log[bw] !== 32'h80001230 || wr_a_log[bw+1] !== exp2 ||
                wr_d_log[bw] !== 32'h11111111 || wr_d_log[bw+1] !== 32'h22222222) begin
                errors++;
                $display("FAIL inc_writes: got %h/%h %h/%h expected 80001230/11111111 %h/22222222",
                         wr_a_log[bw], wr_d_log[bw], wr_a_log[bw+1], wr_d_log[bw+1], exp2);
            end
        end
    endtask

    task automatic test_abort_write();
        int cyc; bit to; int bw; int bf;
        clear_rom();
        rom_mem[0] = 34'h290000100;
        rom_mem[1] = 34'h3c0000014;
        rom_mem[2] = 34'h3deadbeef;
        bus.wr_ready = 1'b0;
        bw = wr_a_log.size();
        bf = n_fetch;
        do_start(1'b0);
        wait_valid(20, cyc, to);
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wr_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold_%0d: got v=%b done=%b expected 1 0", i, bus.wr_valid, done);
            end
            @(posedge clk); #1;
        end
        bus.wr_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({done, bus.wr_valid} !== 2'b10) begin
            errors++;
            $display("FAIL abort_done: got done=%b v=%b expected 1 0", done, bus.wr_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_fetch - bf != 2 || wr_a_log.size() - bw != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_totals: got fetch=%0d writes=%0d done=%b expected 2 1 1",
                     n_fetch - bf, wr_a_log.size() - bw, done);
        end else begin
            checks++;
            if (wr_d_log[bw] !== 32'hC0000014) begin
                errors++;
                $display("FAIL abort_data: got %h expected c0000014", wr_d_log[bw]);
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_pc_end();
        int cyc; bit to; int bc;
        for (int i = 0; i < 256; i++) rom_mem[i] = {2'b01, 32'(i)};
        bc = cfg_log.size();
        do_start(1'b0);
        wait_done(2000, cyc, to);
        checks++;
        if (to || cyc != 512) begin
            errors++;
            $display("FAIL pcend_latency: got %0d (timeout=%0d) expected 512", cyc, to);
        end
        checks++;
        if ({err, rom_addr} !== {1'b1, 8'hFF} || cfg_log.size() - bc != 256) begin
            errors++;
            $display("FAIL pcend_status: got err=%b pc=%h cfg=%0d expected 1 ff 256",
                     err, rom_addr, cfg_log.size() - bc);
        end else begin
            checks++;
            if (cfg_log[bc+255] !== 32'h000000FF) begin
                errors++;
                $display("FAIL pcend_last_cfg: got %h expected 000000ff", cfg_log[bc+255]);
            end
        end
    endtask

    task automatic test_abort_with_start();
        int bf; int bc;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_rom();
        rom_mem[0] = 34'h100000001;
        bf = n_fetch;
        bc = cfg_log.size();
        do_start(1'b1);
        checks++;
        if ({busy, rom_en} !== 2'b11) begin
            errors++;
            $display("FAIL abst_start_wins: got busy=%b en=%b expected 1 1", busy, rom_en);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b10 || n_fetch - bf != 1 || cfg_log.size() != bc) begin
            errors++;
            $display("FAIL abst_done: got done=%b busy=%b fetch=%0d cfg=%0d expected 1 0 1 0",
                     done, busy, n_fetch - bf, cfg_log.size() - bc);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int cyc; bit to;
        clear_rom();
        rom_mem[0] = 34'h290000100;
        rom_mem[1] = 34'h3c0000014;
        bus.wr_ready = 1'b0;
        do_start(1'b0);
        wait_valid(20, cyc, to);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (to || {bus.wr_valid, busy, rom_addr} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_write: got v=%b busy=%b pc=%h timeout=%0d expected 0 0 00 0",
                     bus.wr_valid, busy, rom_addr, to);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.wr_ready = 1'b1;
    endtask

    initial begin
        bus.wr_ready = 1'b1;
        clear_rom();
        test_reset();
        test_addr_data_end();
        test_cfg_burst();
        test_backpressure();
        test_data_no_addr();
        test_addr_inc();
        test_abort_write();
        test_pc_end();
        test_abort_with_start();
        test_reset_mid_write();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
